// File: rtl/pw_req_arbiter.sv
// Page-walk request arbiter: one outstanding miss per requester, round-robin
// issue to the shared walker, merging of identical load/store misses, and
// flush sequencing that swallows walks already in flight.
module pw_req_arbiter #(
  parameter int NUM_RQ = 3,
  parameter int ID_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [NUM_RQ-1:0]    IN_miss_valid,
  input  logic [NUM_RQ*20-1:0] IN_miss_vpn,
  output logic [NUM_RQ-1:0]    OUT_miss_ready,
  output logic [NUM_RQ-1:0]    OUT_done,
  output logic                 OUT_pw_valid,
  output logic [19:0]          OUT_pw_vpn,
  output logic [ID_W-1:0]      OUT_pw_rqID,
  input  logic                 IN_pw_ready,
  input  logic                 IN_pw_res_valid,
  input  logic [ID_W-1:0]      IN_pw_res_rqID,
  output logic                 OUT_busy,
  output logic                 OUT_drop
);

  typedef enum logic [1:0] {RQ_NONE, RQ_PEND, RQ_WAIT} rq_state_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WALK, S_DRAIN} fsm_e;

  rq_state_e         rq_state     [NUM_RQ];
  rq_state_e         rq_state_nxt [NUM_RQ];
  logic [19:0]       rq_vpn       [NUM_RQ];
  logic [19:0]       rq_vpn_nxt   [NUM_RQ];
  fsm_e              fsm, fsm_nxt;
  logic [ID_W-1:0]   winner, winner_nxt;
  logic [ID_W-1:0]   rr, rr_nxt;
  logic [NUM_RQ-1:0] done_q, done_nxt;
  logic              drop_q, drop_nxt;

  logic [NUM_RQ-1:0] accept;
  logic [NUM_RQ-1:0] complete;
  logic [NUM_RQ-1:0] merge;
  logic              handshake;
  logic              res_hit;
  logic [19:0]       win_vpn;
  logic              pend_found;
  logic [ID_W-1:0]   pend_sel;

  // State register: per-requester entries, global FSM and output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_RQ; i++) begin
        rq_state[i] <= RQ_NONE;
        rq_vpn[i]   <= '0;
      end
      fsm    <= S_IDLE;
      winner <= '0;
      rr     <= '0;
      done_q <= '0;
      drop_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_RQ; i++) begin
        rq_state[i] <= rq_state_nxt[i];
        rq_vpn[i]   <= rq_vpn_nxt[i];
      end
      fsm    <= fsm_nxt;
      winner <= winner_nxt;
      rr     <= rr_nxt;
      done_q <= done_nxt;
      drop_q <= drop_nxt;
    end
  end

  // Event decode: accepts, walk completion set, merge candidates, RR pick.
  always_comb begin
    handshake  = (fsm == S_ISSUE) && IN_pw_ready;
    res_hit    = (fsm == S_WALK) && IN_pw_res_valid && (IN_pw_res_rqID == winner);
    win_vpn    = rq_vpn[winner];
    accept     = '0;
    complete   = '0;
    merge      = '0;
    pend_found = 1'b0;
    pend_sel   = '0;

    for (int unsigned i = 0; i < NUM_RQ; i++) begin
      accept[i] = IN_miss_valid[i] && (rq_state[i] == RQ_NONE) && !clear;
      if (res_hit) begin
        if (ID_W'(i) == winner)
          complete[i] = 1'b1;
        else if ((i != 0) && (winner != '0) && (rq_state[i] == RQ_WAIT) &&
                 (rq_vpn[i] == win_vpn))
          complete[i] = 1'b1;
      end
    end

    // An entry finishing this cycle is not a merge target: its insert is
    // happening now, so a rider would never see a completion.
    for (int unsigned i = 1; i < NUM_RQ; i++) begin
      for (int unsigned j = 1; j < NUM_RQ; j++) begin
        if (j != i && accept[i]) begin
          if (((rq_state[j] == RQ_PEND) || ((rq_state[j] == RQ_WAIT) && !complete[j])) &&
              (rq_vpn[j] == IN_miss_vpn[i*20 +: 20]))
            merge[i] = 1'b1;
          if ((j < i) && accept[j] &&
              (IN_miss_vpn[j*20 +: 20] == IN_miss_vpn[i*20 +: 20]))
            merge[i] = 1'b1;
        end
      end
    end

    // Round robin as two passes: indices at/after rr first, then wrap.
    for (int unsigned i = 0; i < NUM_RQ; i++) begin
      if (!pend_found && (ID_W'(i) >= rr) && (rq_state[i] == RQ_PEND)) begin
        pend_found = 1'b1;
        pend_sel   = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_RQ; i++) begin
      if (!pend_found && (ID_W'(i) < rr) && (rq_state[i] == RQ_PEND)) begin
        pend_found = 1'b1;
        pend_sel   = ID_W'(i);
      end
    end
  end

  // Next state: clear first, then completion, issue and new accepts.
  always_comb begin
    fsm_nxt    = fsm;
    winner_nxt = winner;
    rr_nxt     = rr;
    done_nxt   = '0;
    drop_nxt   = 1'b0;
    for (int unsigned i = 0; i < NUM_RQ; i++) begin
      rq_state_nxt[i] = rq_state[i];
      rq_vpn_nxt[i]   = rq_vpn[i];
    end

    for (int unsigned i = 0; i < NUM_RQ; i++) begin
      if (clear) begin
        rq_state_nxt[i] = RQ_NONE;
      end else if (complete[i]) begin
        rq_state_nxt[i] = RQ_NONE;
        done_nxt[i]     = 1'b1;
      end else if (handshake && (winner == ID_W'(i))) begin
        rq_state_nxt[i] = RQ_WAIT;
      end else if (accept[i]) begin
        rq_vpn_nxt[i]   = IN_miss_vpn[i*20 +: 20];
        rq_state_nxt[i] = merge[i] ? RQ_WAIT : RQ_PEND;
      end
    end

    case (fsm)
      S_IDLE: begin
        if (!clear && pend_found) begin
          winner_nxt = pend_sel;
          fsm_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (clear) begin
          fsm_nxt = handshake ? S_DRAIN : S_IDLE;
        end else if (handshake) begin
          rr_nxt  = (winner == ID_W'(NUM_RQ - 1)) ? '0 : winner + 1'b1;
          fsm_nxt = S_WALK;
        end
      end
      S_WALK: begin
        if (clear) begin
          if (IN_pw_res_valid) begin
            fsm_nxt  = S_IDLE;
            drop_nxt = 1'b1;
          end else begin
            fsm_nxt = S_DRAIN;
          end
        end else if (res_hit) begin
          fsm_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (IN_pw_res_valid) begin
          fsm_nxt  = S_IDLE;
          drop_nxt = 1'b1;
        end
      end
      default: fsm_nxt = S_IDLE;
    endcase
  end

  // Outputs: ready per requester, walk request, status pulses.
  always_comb begin
    OUT_miss_ready = '0;
    for (int unsigned i = 0; i < NUM_RQ; i++)
      OUT_miss_ready[i] = (rq_state[i] == RQ_NONE) && !clear;
    OUT_pw_valid = (fsm == S_ISSUE);
    OUT_pw_vpn   = win_vpn;
    OUT_pw_rqID  = winner;
    OUT_busy     = (fsm != S_IDLE);
    OUT_done     = done_q;
    OUT_drop     = drop_q;
  end

endmodule
